hit_buffer_addr_ctrl: RTL and testbench

// - Upstream address/trigger controller for the per-pixel hit SRAM circular buffer.
// - Generates the free-running write pointer, one address per 40MHz bunch crossing.
// - Turns each L1A into a read window of windowLen consecutive BCs, starting at
//   (wrAddr at L1A) - l1Latency, modulo 512.
// - Queues pending L1As in a small FIFO and drives rden/rdAddr to the buffer.
// - Flags when the 1-bit hit output of the buffer is valid.

---
 rtl/hit_buffer_addr_ctrl_pkg.sv | 39 +++
 rtl/hit_buffer_addr_ctrl_if.sv | 27 ++
 rtl/hit_buffer_addr_ctrl_fifo.sv | 48 ++++
 rtl/hit_buffer_addr_ctrl.sv | 112 +++++++++++
 tb/tb_hit_buffer_addr_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hit_buffer_addr_ctrl_pkg.sv
// Shared sizing, FSM encoding, pending-window payload and clamp helpers
// for the hit SRAM buffer address/trigger controller.
package hit_buffer_addr_ctrl_pkg;

  localparam int unsigned AW     = 9;
  localparam int unsigned QDEPTH = 4;
  localparam int unsigned MAXWIN = 4;
  localparam int unsigned MINLAT = 8;
  localparam int unsigned WLW    = 3;
  localparam int unsigned QAW    = $clog2(QDEPTH);
  localparam int unsigned MAXLAT = (1 << AW) - 1 - QDEPTH * MAXWIN;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_e;

  typedef struct packed {
    logic [AW-1:0]  start;
    logic [WLW-1:0] len;
  } win_t;

  function automatic logic lat_out_of_range(input logic [AW-1:0] lat);
    return (lat < AW'(MINLAT)) || (lat > AW'(MAXLAT));
  endfunction

  function automatic logic [AW-1:0] clamp_lat(input logic [AW-1:0] lat);
    if (lat < AW'(MINLAT))      return AW'(MINLAT);
    else if (lat > AW'(MAXLAT)) return AW'(MAXLAT);
    else                        return lat;
  endfunction

  function automatic logic [WLW-1:0] clamp_win(input logic [WLW-1:0] w);
    if (w == '0)                 return WLW'(1);
    else if (w > WLW'(MAXWIN))   return WLW'(MAXWIN);
    else                         return w;
  endfunction

endpackage

// File: rtl/hit_buffer_addr_ctrl_if.sv
// Trigger/config inputs and buffer-side address/status outputs of the
// hit buffer controller; the controller uses the slave view.
interface hit_buffer_addr_ctrl_if;
  import hit_buffer_addr_ctrl_pkg::*;

  logic           l1a;
  logic [AW-1:0]  l1Latency;
  logic [WLW-1:0] windowLen;
  logic [AW-1:0]  wrAddr;
  logic [AW-1:0]  rdAddr;
  logic           rden;
  logic           hitValid;
  logic           winLast;
  logic           l1aOverflow;
  logic           latClamped;

  modport master (
    output l1a, l1Latency, windowLen,
    input  wrAddr, rdAddr, rden, hitValid, winLast, l1aOverflow, latClamped
  );

  modport slave (
    input  l1a, l1Latency, windowLen,
    output wrAddr, rdAddr, rden, hitValid, winLast, l1aOverflow, latClamped
  );

endinterface

// File: rtl/hit_buffer_addr_ctrl_fifo.sv
// Pending-L1A FIFO: QDEPTH read windows, same-cycle push and pop allowed;
// head entry is presented combinationally.
module hit_buffer_addr_ctrl_fifo
  import hit_buffer_addr_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  win_t i_wdata,
  input  logic i_pop,
  output win_t o_rdata_c,
  output logic o_empty_c,
  output logic o_full_c
);

  localparam int unsigned CW = QAW + 1;

  win_t           r_mem [QDEPTH];
  logic [QAW-1:0] r_wr_ptr;
  logic [QAW-1:0] r_rd_ptr;
  logic [CW-1:0]  r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + QAW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + QAW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata_c = r_mem[r_rd_ptr];
  assign o_empty_c = (r_count == '0);
  assign o_full_c  = (r_count == CW'(QDEPTH));

endmodule

// File: rtl/hit_buffer_addr_ctrl.sv
// Hit buffer address controller: free-running write pointer, L1A to
// read-window conversion, pending-window queue and read sequencing FSM.
module hit_buffer_addr_ctrl
  import hit_buffer_addr_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dis,
  hit_buffer_addr_ctrl_if.slave bus
);

  state_e         r_state;
  logic [AW-1:0]  r_wr_addr;
  logic [AW-1:0]  r_rd_addr;
  logic [WLW-1:0] r_cnt;
  logic           r_rden;
  logic           r_hit_valid;
  logic           r_win_last;
  logic           r_overflow;
  logic           r_lat_clamped;

  win_t w_new;
  win_t w_head;
  win_t w_load_entry;
  logic w_l1a;
  logic w_free;
  logic w_bypass;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_load;
  logic w_fifo_empty;
  logic w_fifo_full;

  // A window slot frees up when idle or on the last BC of the current window.
  always_comb begin
    w_new.start  = r_wr_addr - clamp_lat(bus.l1Latency);
    w_new.len    = clamp_win(bus.windowLen);
    w_l1a        = bus.l1a & ~dis;
    w_free       = (r_state == IDLE) | (r_cnt == '0);
    w_bypass     = w_free & w_fifo_empty & w_l1a;
    w_pop        = ~dis & w_free & ~w_fifo_empty;
    w_push       = w_l1a & ~w_bypass & (~w_fifo_full | w_pop);
    w_drop       = w_l1a & ~w_bypass & w_fifo_full & ~w_pop;
    w_load       = w_pop | w_bypass;
    w_load_entry = w_pop ? w_head : w_new;
  end

  hit_buffer_addr_ctrl_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_wdata   (w_new),
    .i_pop     (w_pop),
    .o_rdata_c (w_head),
    .o_empty_c (w_fifo_empty),
    .o_full_c  (w_fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
      r_cnt         <= '0;
      r_rden        <= 1'b0;
      r_hit_valid   <= 1'b0;
      r_win_last    <= 1'b0;
      r_overflow    <= 1'b0;
      r_lat_clamped <= 1'b0;
    end else if (!dis) begin
      r_wr_addr   <= r_wr_addr + AW'(1);
      r_overflow  <= w_drop;
      r_hit_valid <= r_rden;
      r_win_last  <= r_rden & (r_cnt == '0);
      if (lat_out_of_range(bus.l1Latency)) r_lat_clamped <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_rd_addr <= w_load_entry.start;
            r_cnt     <= w_load_entry.len - WLW'(1);
            r_rden    <= 1'b1;
            r_state   <= READ;
          end
        end
        READ: begin
          if (r_cnt != '0) begin
            r_rd_addr <= r_rd_addr + AW'(1);
            r_cnt     <= r_cnt - WLW'(1);
          end else if (w_load) begin
            r_rd_addr <= w_load_entry.start;
            r_cnt     <= w_load_entry.len - WLW'(1);
          end else begin
            r_rden  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Disable freezes state; the read strobe is suppressed so the buffer idles.
  assign bus.wrAddr      = r_wr_addr;
  assign bus.rdAddr      = r_rd_addr;
  assign bus.rden        = r_rden & ~dis;
  assign bus.hitValid    = r_hit_valid;
  assign bus.winLast     = r_win_last;
  assign bus.l1aOverflow = r_overflow;
  assign bus.latClamped  = r_lat_clamped;

endmodule

// File: tb/tb_hit_buffer_addr_ctrl.sv
// Self-checking bench for hit_buffer_addr_ctrl: directed scenarios plus
// randomized traffic against a queue-based window model.
module tb_hit_buffer_addr_ctrl;
  import hit_buffer_addr_ctrl_pkg::*;

  typedef struct {
    int start;
    int len;
  } mwin_t;

  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  logic dis;

  hit_buffer_addr_ctrl_if bus ();

  hit_buffer_addr_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .dis   (dis),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: write pointer, pending windows, window being read.
  int    m_wr, m_addr, m_rem;
  bit    m_hv, m_wl, m_ovf, m_latc;
  mwin_t m_q[$];

  task automatic tick();
    int    lat;
    int    w;
    mwin_t e;
    if (reset) begin
      m_wr = 0; m_addr = 0; m_rem = 0;
      m_hv = 0; m_wl = 0; m_ovf = 0; m_latc = 0;
      m_q.delete();
    end else if (!dis) begin
      lat = int'(bus.l1Latency);
      if (lat < int'(MINLAT)) begin lat = int'(MINLAT); m_latc = 1; end
      else if (lat > int'(MAXLAT)) begin lat = int'(MAXLAT); m_latc = 1; end
      w = int'(bus.windowLen);
      if (w == 0) w = 1;
      else if (w > int'(MAXWIN)) w = int'(MAXWIN);
      m_hv = (m_rem > 0);
      m_wl = (m_rem == 1);
      if (bus.l1a) begin
        e.start = (m_wr - lat + DEPTH) % DEPTH;
        e.len   = w;
        m_q.push_back(e);
      end
      if (m_rem <= 1 && m_q.size() > 0) begin
        e = m_q.pop_front();
        m_addr = e.start;
        m_rem  = e.len;
      end else if (m_rem > 1) begin
        m_addr = (m_addr + 1) % DEPTH;
        m_rem--;
      end else begin
        m_rem = 0;
      end
      m_ovf = 0;
      if (m_q.size() > int'(QDEPTH)) begin
        void'(m_q.pop_back());
        m_ovf = 1;
      end
      m_wr = (m_wr + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*AW+4:0] exp_vec();
    return {AW'(m_wr), AW'(m_addr), (m_rem > 0) && !dis, m_hv, m_wl, m_ovf, m_latc};
  endfunction

  function automatic logic [2*AW+4:0] obs_vec();
    return {bus.wrAddr, bus.rdAddr, bus.rden, bus.hitValid, bus.winLast,
            bus.l1aOverflow, bus.latClamped};
  endfunction

  task automatic test_reset();
    reset = 1'b1; dis = 1'b0; bus.l1a = 1'b0;
    bus.l1Latency = AW'(20); bus.windowLen = WLW'(1);
    tick(); tick();
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_vec: got %h want %h", obs_vec(), exp_vec());
    end
    n_cmp++;
    if (bus.wrAddr !== '0 || bus.rden !== 1'b0 || bus.latClamped !== 1'b0) begin
      n_fail++; $display("FAIL reset_vals: got wr=%0d rden=%b lc=%b want 0 0 0",
                         bus.wrAddr, bus.rden, bus.latClamped);
    end
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    for (int k = 1; k <= 600; k++) begin
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL wrap_vec k=%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (k == 511 || k == 512) begin
        n_cmp++;
        if (bus.wrAddr !== AW'(k % 512)) begin
          n_fail++; $display("FAIL wrap_addr k=%0d: got %0d want %0d", k, bus.wrAddr, k % 512);
        end
      end
    end
  endtask

  task automatic test_single();
    bus.l1Latency = AW'(20); bus.windowLen = WLW'(1);
    for (int k = 0; k < DEPTH && m_wr != 100; k++) tick();
    bus.l1a = 1'b1;
    tick();
    bus.l1a = 1'b0;
    n_cmp++;
    if (bus.rden !== 1'b1 || bus.rdAddr !== AW'(80)) begin
      n_fail++; $display("FAIL single_first: got rden=%b rd=%0d want 1 80", bus.rden, bus.rdAddr);
    end
    tick();
    n_cmp++;
    if (bus.hitValid !== 1'b1 || bus.winLast !== 1'b1 || bus.rden !== 1'b0) begin
      n_fail++; $display("FAIL single_valid: got hv=%b wl=%b rden=%b want 1 1 0",
                         bus.hitValid, bus.winLast, bus.rden);
    end
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL single_vec: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_window3();
    bus.windowLen = WLW'(3);
    for (int k = 0; k < DEPTH && m_wr != 5; k++) tick();
    bus.l1a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.l1a = 1'b0;
      n_cmp++;
      if (i < 3) begin
        if (bus.rden !== 1'b1 || bus.rdAddr !== AW'(497 + i)) begin
          n_fail++; $display("FAIL win3_seq i=%0d: got rden=%b rd=%0d want 1 %0d",
                             i, bus.rden, bus.rdAddr, 497 + i);
        end
      end else if (bus.rden !== 1'b0) begin
        n_fail++; $display("FAIL win3_end i=%0d: got rden=%b want 0", i, bus.rden);
      end
    end
  endtask

  task automatic test_back_to_back();
    int run = 0, maxrun = 0, novf = 0;
    bus.windowLen = WLW'(4); bus.l1Latency = AW'(20);
    for (int k = 0; k < 6; k++) tick();
    for (int i = 0; i < 40; i++) begin
      bus.l1a = (i < 7);
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL b2b_vec i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      run = bus.rden ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (bus.l1aOverflow === 1'b1) novf++;
    end
    bus.l1a = 1'b0;
    n_cmp++;
    if (maxrun !== 24 || novf !== 1) begin
      n_fail++; $display("FAIL b2b_burst: got run=%0d ovf=%0d want 24 1", maxrun, novf);
    end
  endtask

  task automatic test_clamp();
    int w;
    bus.windowLen = WLW'(1);
    bus.l1Latency = AW'(3);
    tick();
    n_cmp++;
    if (bus.latClamped !== 1'b1) begin
      n_fail++; $display("FAIL clamp_low_flag: got %b want 1", bus.latClamped);
    end
    w = m_wr;
    bus.l1a = 1'b1; tick(); bus.l1a = 1'b0;
    n_cmp++;
    if (bus.rden !== 1'b1 || bus.rdAddr !== AW'((w + DEPTH - 8) % DEPTH)) begin
      n_fail++; $display("FAIL clamp_low_addr: got rden=%b rd=%0d want 1 %0d",
                         bus.rden, bus.rdAddr, (w + DEPTH - 8) % DEPTH);
    end
    bus.l1Latency = AW'(510);
    for (int k = 0; k < 3; k++) tick();
    w = m_wr;
    bus.l1a = 1'b1; tick(); bus.l1a = 1'b0;
    n_cmp++;
    if (bus.rdAddr !== AW'((w + DEPTH - 495) % DEPTH) || bus.latClamped !== 1'b1) begin
      n_fail++; $display("FAIL clamp_high: got rd=%0d lc=%b want %0d 1",
                         bus.rdAddr, bus.latClamped, (w + DEPTH - 495) % DEPTH);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.l1Latency = AW'(20); bus.windowLen = WLW'(4);
    for (int k = 0; k < 6; k++) tick();
    // Windows e0..e3; reset lands on the 2nd BC of e1 with e2, e3 queued.
    for (int i = 0; i < 6; i++) begin
      bus.l1a = (i < 4);
      tick();
    end
    bus.l1a = 1'b0;
    n_cmp++;
    if (bus.rden !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL rstmid_pre: got %h want %h", obs_vec(), exp_vec());
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (bus.rden !== 1'b0 || bus.wrAddr !== '0) begin
      n_fail++; $display("FAIL rstmid_post: got rden=%b wr=%0d want 0 0", bus.rden, bus.wrAddr);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if (bus.rden !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rstmid_flush i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_dis();
    int w;
    tick();
    w = m_wr;
    dis = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.l1a = 1'($urandom_range(0, 1));
      tick();
      n_cmp++;
      if (bus.wrAddr !== AW'(w) || bus.rden !== 1'b0) begin
        n_fail++; $display("FAIL dis_hold i=%0d: got wr=%0d rden=%b want %0d 0",
                           i, bus.wrAddr, bus.rden, w);
      end
    end
    dis = 1'b0; bus.l1a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (bus.rden !== 1'b0 || obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL dis_after i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int p = 10;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        bus.l1Latency = AW'($urandom_range(0, DEPTH - 1));
        bus.windowLen = WLW'($urandom_range(0, 7));
        case ($urandom_range(0, 2))
          0:       p = 5;
          1:       p = 30;
          default: p = 60;
        endcase
      end
      bus.l1a = ($urandom_range(0, 99) < p);
      dis     = ($urandom_range(0, 19) == 0);
      reset   = ($urandom_range(0, 499) == 0);
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_vec i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    bus.l1a = 1'b0; dis = 1'b0; reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; dis = 1'b0;
    bus.l1a = 1'b0; bus.l1Latency = AW'(20); bus.windowLen = WLW'(1);
    test_reset();
    test_wrap();
    test_single();
    test_window3();
    test_back_to_back();
    test_clamp();
    test_reset_mid();
    test_dis();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit reached want bench completion");
    $fatal(1, "bench timeout");
  end

endmodule
